// File: rtl/vga_pkg.sv
// Shared timing constants, colour-field slices and a colour-select helper for the VGA signal generator.
package vga_pkg;

    localparam int CLK_DIV = 4;

    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int V_VIS  = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_VIS + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VIS + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int COUNT_W  = 10;
    localparam int ADDR_W   = 15;
    localparam int ADDR_X_W = 8;
    localparam int ADDR_Y_W = 7;

    localparam int FG_MSB = 15;
    localparam int FG_LSB = 8;
    localparam int BG_MSB = 7;
    localparam int BG_LSB = 0;

    typedef logic [7:0] colour_t;

    function automatic colour_t pickColour(input logic [15:0] cfg, input logic useFg);
        return useFg ? cfg[FG_MSB:FG_LSB] : cfg[BG_MSB:BG_LSB];
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Pixel-tick divider plus horizontal/vertical scan counters and the frame-start pulse.
module vga_timing_counter #(
    parameter int CLK_DIV = vga_pkg::CLK_DIV,
    parameter int H_VIS   = vga_pkg::H_VIS,
    parameter int H_FP    = vga_pkg::H_FP,
    parameter int H_SYNC  = vga_pkg::H_SYNC,
    parameter int H_BP    = vga_pkg::H_BP,
    parameter int V_VIS   = vga_pkg::V_VIS,
    parameter int V_FP    = vga_pkg::V_FP,
    parameter int V_SYNC  = vga_pkg::V_SYNC,
    parameter int V_BP    = vga_pkg::V_BP
) (
    input  logic                        clk_i,
    input  logic                        rstN_i,
    output logic                        tick_o,
    output logic [vga_pkg::COUNT_W-1:0] h_o,
    output logic [vga_pkg::COUNT_W-1:0] v_o,
    output logic [vga_pkg::COUNT_W-1:0] nextH_o,
    output logic [vga_pkg::COUNT_W-1:0] nextV_o,
    output logic                        visible_o,
    output logic                        frameStart_o
);
    import vga_pkg::*;

    localparam int DIV_W    = $clog2(CLK_DIV);
    localparam int LINE_LEN = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int NUM_LINE = V_VIS + V_FP + V_SYNC + V_BP;

    logic [DIV_W-1:0]   divCount_q, divCount_d;
    logic [COUNT_W-1:0] hCount_q, hCount_d;
    logic [COUNT_W-1:0] vCount_q, vCount_d;
    logic               restart_q;
    logic               frameStart_q, frameStart_d;
    logic               tick;

    always_comb begin
        tick         = (divCount_q == DIV_W'(CLK_DIV - 1));
        divCount_d   = tick ? '0 : divCount_q + 1'b1;
        hCount_d     = hCount_q;
        vCount_d     = vCount_q;
        if (tick) begin
            if (hCount_q == COUNT_W'(LINE_LEN - 1)) begin
                hCount_d = '0;
                vCount_d = (vCount_q == COUNT_W'(NUM_LINE - 1)) ? '0 : vCount_q + 1'b1;
            end else begin
                hCount_d = hCount_q + 1'b1;
            end
        end
        // The first edge out of reset counts as a frame start as well as every wrap to the origin.
        frameStart_d = restart_q || (tick && (hCount_d == '0) && (vCount_d == '0));
    end

    always_ff @(posedge clk_i) begin
        if (!rstN_i) begin
            divCount_q   <= '0;
            hCount_q     <= '0;
            vCount_q     <= '0;
            restart_q    <= 1'b1;
            frameStart_q <= 1'b0;
        end else begin
            divCount_q   <= divCount_d;
            hCount_q     <= hCount_d;
            vCount_q     <= vCount_d;
            restart_q    <= 1'b0;
            frameStart_q <= frameStart_d;
        end
    end

    assign tick_o       = tick;
    assign h_o          = hCount_q;
    assign v_o          = vCount_q;
    assign nextH_o      = hCount_d;
    assign nextV_o      = vCount_d;
    assign visible_o    = (hCount_q < COUNT_W'(H_VIS)) && (vCount_q < COUNT_W'(V_VIS));
    assign frameStart_o = frameStart_q;

endmodule

// File: rtl/vga_sig_gen.sv
// 640x480 VGA generator scanning a 160x120 1-bpp frame buffer with 4x4 pixel scaling.
// Optional build macro VGA_BORDER_EN forces the outermost visible ring to the foreground colour.
module vga_sig_gen #(
    parameter int CLK_DIV = vga_pkg::CLK_DIV,
    parameter int H_VIS   = vga_pkg::H_VIS,
    parameter int H_FP    = vga_pkg::H_FP,
    parameter int H_SYNC  = vga_pkg::H_SYNC,
    parameter int H_BP    = vga_pkg::H_BP,
    parameter int V_VIS   = vga_pkg::V_VIS,
    parameter int V_FP    = vga_pkg::V_FP,
    parameter int V_SYNC  = vga_pkg::V_SYNC,
    parameter int V_BP    = vga_pkg::V_BP
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] CONFIG_COLOURS,
    input  logic        VGA_DATA,
    output logic [14:0] VGA_ADDR,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic [7:0]  VGA_COLOUR,
    output logic        FRAME_START
);
    import vga_pkg::*;

    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic               tick, visible, nextVisible, inBorder, frameStart;
    logic [COUNT_W-1:0] hCount, vCount, nextH, nextV;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               hs_q, hs_d, vs_q, vs_d;
    colour_t            colour_q, colour_d, pixelColour;

    vga_timing_counter #(
        .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) uTiming (
        .clk_i        (CLK),
        .rstN_i       (RESET),
        .tick_o       (tick),
        .h_o          (hCount),
        .v_o          (vCount),
        .nextH_o      (nextH),
        .nextV_o      (nextV),
        .visible_o    (visible),
        .frameStart_o (frameStart)
    );

    // Address stage: request the pixel the counters are about to show; hold through blanking.
    always_comb begin
        addr_d      = addr_q;
        nextVisible = (nextH < COUNT_W'(H_VIS)) && (nextV < COUNT_W'(V_VIS));
        if (tick && nextVisible) begin
            addr_d = {ADDR_Y_W'(nextV >> 2), ADDR_X_W'(nextH >> 2)};
        end
    end

    // Output stage: the current counters name the pixel whose address went out one tick ago.
    always_comb begin
        inBorder = 1'b0;
`ifdef VGA_BORDER_EN
        inBorder = (hCount == '0) || (hCount == COUNT_W'(H_VIS - 1)) ||
                   (vCount == '0) || (vCount == COUNT_W'(V_VIS - 1));
`endif
        pixelColour = pickColour(CONFIG_COLOURS, VGA_DATA || inBorder);
        colour_d    = colour_q;
        hs_d        = hs_q;
        vs_d        = vs_q;
        if (tick) begin
            colour_d = visible ? pixelColour : '0;
            hs_d     = !((hCount >= COUNT_W'(HS_START)) && (hCount < COUNT_W'(HS_END)));
            vs_d     = !((vCount >= COUNT_W'(VS_START)) && (vCount < COUNT_W'(VS_END)));
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            addr_q   <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            colour_q <= '0;
        end else begin
            addr_q   <= addr_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            colour_q <= colour_d;
        end
    end

    assign VGA_ADDR    = addr_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_COLOUR  = colour_q;
    assign FRAME_START = frameStart;

endmodule

// File: tb/tb_vga_sig_gen.sv
// Directed bench for vga_sig_gen on a shrunken raster (16x12 visible, 24x16 total, 2 CLK per pixel)
// so whole frames fit in a short run; expectations follow the same rules scaled to that geometry.
module tb_vga_sig_gen;

    localparam int CLK_DIV   = 2;
    localparam int H_VIS     = 16;
    localparam int V_VIS     = 12;
    localparam int H_TOTAL   = 24;
    localparam int FRAME_PIX = 384;

`ifdef VGA_BORDER_EN
    localparam bit BORDER_ON = 1'b1;
`else
    localparam bit BORDER_ON = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [15:0] CONFIG_COLOURS = 16'h0000;
    logic        VGA_DATA;
    logic [14:0] VGA_ADDR;
    logic        VGA_HS;
    logic        VGA_VS;
    logic [7:0]  VGA_COLOUR;
    logic        FRAME_START;

    int compared = 0;
    int mismatched = 0;
    int fbMode = 0;

    vga_sig_gen #(
        .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VIS(V_VIS), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .CONFIG_COLOURS (CONFIG_COLOURS),
        .VGA_DATA       (VGA_DATA),
        .VGA_ADDR       (VGA_ADDR),
        .VGA_HS         (VGA_HS),
        .VGA_VS         (VGA_VS),
        .VGA_COLOUR     (VGA_COLOUR),
        .FRAME_START    (FRAME_START)
    );

    always #5 CLK = ~CLK;

    // Frame-buffer contents: 0 = all clear, 1 = only address 1 set, 2 = all set
    function automatic logic fbBit(input logic [14:0] a);
        case (fbMode)
            1:       return (a == 15'h0001);
            2:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Synchronous read port: data for an address appears one CLK later
    always @(posedge CLK) VGA_DATA <= fbBit(VGA_ADDR);

    function automatic logic [7:0] expPixel(input int h, input int v, input logic [15:0] cfg);
        logic [14:0] a;
        logic        b;
        if (h >= H_VIS || v >= V_VIS) return 8'h00;
        a = {7'(v / 4), 8'(h / 4)};
        b = fbBit(a);
        if (BORDER_ON && (h == 0 || h == H_VIS - 1 || v == 0 || v == V_VIS - 1)) b = 1'b1;
        return b ? cfg[15:8] : cfg[7:0];
    endfunction

    task automatic waitEdge();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic startScan();
        RESET = 1'b0;
        waitEdge();
        waitEdge();
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        fbMode = 2;
        CONFIG_COLOURS = 16'hE003;
        RESET = 1'b0;
        waitEdge();
        waitEdge();
        compared++; if (VGA_HS !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_hs: got %b required 1", VGA_HS); end
        compared++; if (VGA_VS !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_vs: got %b required 1", VGA_VS); end
        compared++; if (VGA_COLOUR !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_colour: got %h required 00", VGA_COLOUR); end
        compared++; if (FRAME_START !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_frame_start: got %b required 0", FRAME_START); end
        compared++; if (VGA_ADDR !== 15'h0000) begin mismatched++; $display("[TB] FAIL reset_addr: got %h required 0000", VGA_ADDR); end
    endtask

    task automatic test_sync_timing();
        int   hsFalls, vsFalls, fsCount, lastHsFall, lastVsFall;
        logic prevHs, prevVs;
        hsFalls = 0; vsFalls = 0; fsCount = 0; lastHsFall = -1; lastVsFall = -1;
        prevHs = 1'b1; prevVs = 1'b1;
        fbMode = 0;
        CONFIG_COLOURS = 16'hE003;
        startScan();
        for (int n = 1; n <= 1535; n++) begin
            waitEdge();
            if (FRAME_START) begin
                fsCount++;
                compared++;
                if (n != 1 && n != 768) begin mismatched++; $display("[TB] FAIL frame_start_pos: pulse at edge %0d required edge 1 or 768", n); end
            end
            if (prevHs && !VGA_HS) begin
                compared++;
                if (lastHsFall < 0) begin
                    if (n != 38) begin mismatched++; $display("[TB] FAIL hs_first_fall: got edge %0d required 38", n); end
                end else if (n - lastHsFall != 48) begin
                    mismatched++; $display("[TB] FAIL hs_period: got %0d CLK required 48", n - lastHsFall);
                end
                lastHsFall = n;
                hsFalls++;
            end
            if (!prevHs && VGA_HS) begin
                compared++;
                if (n - lastHsFall != 8) begin mismatched++; $display("[TB] FAIL hs_width: got %0d CLK required 8", n - lastHsFall); end
            end
            if (prevVs && !VGA_VS) begin
                compared++;
                if (lastVsFall < 0) begin
                    if (n != 626) begin mismatched++; $display("[TB] FAIL vs_first_fall: got edge %0d required 626", n); end
                end else if (n - lastVsFall != 768) begin
                    mismatched++; $display("[TB] FAIL vs_period: got %0d CLK required 768", n - lastVsFall);
                end
                lastVsFall = n;
                vsFalls++;
            end
            if (!prevVs && VGA_VS) begin
                compared++;
                if (n - lastVsFall != 96) begin mismatched++; $display("[TB] FAIL vs_width: got %0d CLK required 96", n - lastVsFall); end
            end
            prevHs = VGA_HS;
            prevVs = VGA_VS;
        end
        compared++; if (hsFalls != 32) begin mismatched++; $display("[TB] FAIL hs_fall_count: got %0d required 32", hsFalls); end
        compared++; if (vsFalls != 2) begin mismatched++; $display("[TB] FAIL vs_fall_count: got %0d required 2", vsFalls); end
        compared++; if (fsCount != 2) begin mismatched++; $display("[TB] FAIL frame_start_count: got %0d required 2", fsCount); end
    endtask

    task automatic test_pixel_colour();
        int p;
        logic [7:0] expCol;
        fbMode = 1;
        CONFIG_COLOURS = 16'hE003;
        startScan();
        waitEdge();
        for (int k = 1; k <= FRAME_PIX; k++) begin
            p = k - 1;
            expCol = expPixel(p % H_TOTAL, p / H_TOTAL, CONFIG_COLOURS);
            for (int e = 0; e < 2; e++) begin
                waitEdge();
                compared++;
                if (VGA_COLOUR !== expCol) begin
                    mismatched++;
                    $display("[TB] FAIL pixel_colour h=%0d v=%0d: got %h required %h", p % H_TOTAL, p / H_TOTAL, VGA_COLOUR, expCol);
                end
            end
        end
    endtask

    task automatic test_address();
        int          n;
        int          chkN [8];
        logic [14:0] chkA [8];
        chkN = '{1, 10, 32, 46, 48, 208, 444, 558};
        chkA = '{15'h0000, 15'h0001, 15'h0003, 15'h0003, 15'h0000, 15'h0102, 15'h0201, 15'h0203};
        fbMode = 0;
        CONFIG_COLOURS = 16'h0000;
        startScan();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            while (n < chkN[i]) begin waitEdge(); n++; end
            compared++;
            if (VGA_ADDR !== chkA[i]) begin mismatched++; $display("[TB] FAIL addr_edge%0d: got %h required %h", n, VGA_ADDR, chkA[i]); end
        end
        for (int m = 559; m <= 767; m++) begin
            waitEdge();
            n++;
            compared++;
            if (VGA_ADDR !== 15'h0203) begin mismatched++; $display("[TB] FAIL addr_blank_edge%0d: got %h required 0203", n, VGA_ADDR); end
        end
        waitEdge();
        compared++;
        if (VGA_ADDR !== 15'h0000) begin mismatched++; $display("[TB] FAIL addr_wrap: got %h required 0000", VGA_ADDR); end
    endtask

    task automatic test_reset_midline();
        int         fsCount;
        logic [7:0] expFirst;
        fbMode = 1;
        CONFIG_COLOURS = 16'hE003;
        expFirst = BORDER_ON ? 8'hE0 : 8'h03;
        startScan();
        for (int n = 1; n <= 308; n++) waitEdge();
        compared++; if (VGA_COLOUR !== 8'h03) begin mismatched++; $display("[TB] FAIL midline_pre_colour: got %h required 03", VGA_COLOUR); end
        RESET = 1'b0;
        waitEdge();
        compared++; if (VGA_HS !== 1'b1) begin mismatched++; $display("[TB] FAIL midline_reset_hs: got %b required 1", VGA_HS); end
        compared++; if (VGA_VS !== 1'b1) begin mismatched++; $display("[TB] FAIL midline_reset_vs: got %b required 1", VGA_VS); end
        compared++; if (VGA_COLOUR !== 8'h00) begin mismatched++; $display("[TB] FAIL midline_reset_colour: got %h required 00", VGA_COLOUR); end
        compared++; if (VGA_ADDR !== 15'h0000) begin mismatched++; $display("[TB] FAIL midline_reset_addr: got %h required 0000", VGA_ADDR); end
        RESET = 1'b1;
        waitEdge();
        compared++; if (FRAME_START !== 1'b1) begin mismatched++; $display("[TB] FAIL restart_frame_start: got %b required 1", FRAME_START); end
        fsCount = 0;
        for (int n = 2; n <= 100; n++) begin
            waitEdge();
            if (FRAME_START) fsCount++;
            if (n == 2) begin
                compared++;
                if (VGA_COLOUR !== expFirst) begin mismatched++; $display("[TB] FAIL restart_first_pixel: got %h required %h", VGA_COLOUR, expFirst); end
            end
            if (n == 10) begin
                compared++;
                if (VGA_ADDR !== 15'h0001) begin mismatched++; $display("[TB] FAIL restart_addr: got %h required 0001", VGA_ADDR); end
            end
            if (n == 37) begin
                compared++;
                if (VGA_HS !== 1'b1) begin mismatched++; $display("[TB] FAIL restart_hs_pre: got %b required 1", VGA_HS); end
            end
            if (n == 38) begin
                compared++;
                if (VGA_HS !== 1'b0) begin mismatched++; $display("[TB] FAIL restart_hs_fall: got %b required 0", VGA_HS); end
            end
        end
        compared++; if (fsCount != 0) begin mismatched++; $display("[TB] FAIL restart_extra_pulses: got %0d required 0", fsCount); end
    endtask

    task automatic test_colour_change();
        fbMode = 2;
        CONFIG_COLOURS = 16'hFF00;
        startScan();
        for (int n = 1; n <= 250; n++) waitEdge();
        compared++; if (VGA_COLOUR !== 8'hFF) begin mismatched++; $display("[TB] FAIL colour_old_a: got %h required FF", VGA_COLOUR); end
        waitEdge();
        waitEdge();
        compared++; if (VGA_COLOUR !== 8'hFF) begin mismatched++; $display("[TB] FAIL colour_old_b: got %h required FF", VGA_COLOUR); end
        CONFIG_COLOURS = 16'h00FF;
        waitEdge();
        compared++; if (VGA_COLOUR !== 8'hFF) begin mismatched++; $display("[TB] FAIL colour_between_ticks: got %h required FF", VGA_COLOUR); end
        waitEdge();
        compared++; if (VGA_COLOUR !== 8'h00) begin mismatched++; $display("[TB] FAIL colour_new_a: got %h required 00", VGA_COLOUR); end
        waitEdge();
        compared++; if (VGA_COLOUR !== 8'h00) begin mismatched++; $display("[TB] FAIL colour_new_b: got %h required 00", VGA_COLOUR); end
    endtask

    task automatic test_border();
        int h, v;
        logic [7:0] expCol;
        fbMode = 0;
        CONFIG_COLOURS = 16'h1C00;
        startScan();
        waitEdge();
        for (int k = 1; k <= FRAME_PIX; k++) begin
            waitEdge();
            waitEdge();
            h = (k - 1) % H_TOTAL;
            v = (k - 1) / H_TOTAL;
            expCol = (BORDER_ON && h < H_VIS && v < V_VIS &&
                      (h == 0 || h == H_VIS - 1 || v == 0 || v == V_VIS - 1)) ? 8'h1C : 8'h00;
            compared++;
            if (VGA_COLOUR !== expCol) begin
                mismatched++;
                $display("[TB] FAIL border h=%0d v=%0d: got %h required %h", h, v, VGA_COLOUR, expCol);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_sync_timing();
        test_pixel_colour();
        test_address();
        test_reset_midline();
        test_colour_change();
        test_border();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vga_sig_gen.md
Name: vga_sig_gen

Overview:
VGA signal generator that reads the 160x120 1-bpp frame buffer through its read-only VGA port and drives a 640x480@60Hz display. It generates HS/VS, scans frame-buffer addresses, and maps each returned bit to a configurable 8-bit foreground or background colour. Each frame-buffer pixel is scaled to 4x4 screen pixels. It also emits a frame-start pulse that the microprocessor side uses to synchronise updates.

Parameters:
CLK_DIV, 4, CLK cycles per pixel tick (100 MHz CLK -> 25 MHz pixel rate); legal range >= 2.
H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels; total 800.
V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines; total 525.

Ports:
CLK  in  1  system clock; also drives the frame-buffer read port.
RESET  in  1  synchronous, active-low reset.
CONFIG_COLOURS  in  16  [15:8] foreground, [7:0] background, RGB 3-3-2.
VGA_DATA  in  1  pixel bit from the frame buffer; valid 1 CLK after VGA_ADDR.
VGA_ADDR  out  15  frame-buffer address: [7:0] X = h/4, [14:8] Y = v/4.
VGA_HS  out  1  horizontal sync, active-low.
VGA_VS  out  1  vertical sync, active-low.
VGA_COLOUR  out  8  RGB 3-3-2 pixel; 0 during blanking.
FRAME_START  out  1  one-CLK pulse at h=0, v=0.

Behaviour:
- Reset (RESET=0 at a CLK edge) clears the divider, h, v and VGA_ADDR to 0. It sets VGA_HS=1, VGA_VS=1, VGA_COLOUR=0 and FRAME_START=0. Reset mid-frame restarts the scan at h=0, v=0 on the first edge with RESET=1.
- Divider: counts 0..CLK_DIV-1. The pixel tick is asserted when the divider equals CLK_DIV-1.
- On each tick, h increments and wraps 799->0. When h wraps, v increments and wraps 524->0.
- Address stage: on each tick, VGA_ADDR is registered from the next (h,v) as {v[8:2], h[9:2]}.
  - When next (h,v) is outside the visible area, VGA_ADDR holds its last value.
  - The frame buffer returns VGA_DATA one CLK later, which is before the following tick.
- Output stage: on each tick, the block registers the pixel for the (h,v) whose address was issued on the previous tick.
  - VGA_COLOUR = VGA_DATA ? CONFIG_COLOURS[15:8] : CONFIG_COLOURS[7:0] when that pixel is visible; otherwise 0.
  - VGA_HS = 0 when that pixel's h is in 656..751. VGA_VS = 0 when that pixel's v is in 490..491.
  - HS, VS and COLOUR are therefore mutually aligned, with a fixed one-tick lag behind the counters.
- Boundaries:
  - h=639 -> 640 enters blanking.
  - v=479 -> 480 enters vertical blanking; the address does not advance into Y >= 120.
  - X never exceeds 159 and Y never exceeds 119 while visible.
- FRAME_START: a single CLK pulse on the CLK edge where the counters update to h=0, v=0. Its period is 800*525*CLK_DIV CLK.
- CONFIG_COLOURS is sampled every tick; a change takes effect on the next tick.

Optional Feature:
VGA_BORDER_EN defined:
- Visible pixels with h in {0, 639} or v in {0, 479} output CONFIG_COLOURS[15:8] regardless of VGA_DATA.
- The frame-buffer address sequence is unchanged.
VGA_BORDER_EN undefined:
- All visible pixels come from VGA_DATA; no border logic is synthesised.

Decomposition:
- Package vga_pkg:
  - timing constants H_VIS..V_BP;
  - derived totals H_TOTAL=800 and V_TOTAL=525;
  - sync start/end values 656/752 and 490/492;
  - the colour-field slice constants.
- Sub-module vga_timing_counter:
  - contains the divider and h/v counters;
  - outputs tick, h, v, next_h, next_v, visible and frame_start.
- The top level holds the address and output stages.

Test Plan:
1. Release reset, run 2 frames. Required:
   - VGA_HS falls every 3200 CLK and stays low for 384 CLK.
   - VGA_VS stays low for 2*3200 CLK every 1,680,000 CLK.
   - FRAME_START pulses exactly twice.
2. Frame-buffer model with Mem[{7'd0,8'd1}]=1 and all else 0, CONFIG_COLOURS=16'hE003. Required:
   - screen pixels h=4..7, v=0..3 output 8'hE0;
   - h=0..3 output 8'h03;
   - every blanking pixel outputs 8'h00.
3. Address check. Required:
   - on the tick issuing (h=639, v=479), VGA_ADDR = {7'd119, 8'd159} = 15'h779F;
   - VGA_ADDR is unchanged throughout blanking.
4. Assert RESET low for 1 CLK mid-line at h=300, v=200. Required:
   - the next edge shows VGA_HS=1, VGA_VS=1, VGA_COLOUR=0;
   - after release the counters restart at h=0, v=0 and FRAME_START pulses once.
5. Change CONFIG_COLOURS from 16'hFF00 to 16'h00FF on a tick with VGA_DATA=1. Required:
   - VGA_COLOUR changes from 8'hFF to 8'h00 on the next tick, with no glitch between ticks.
6. With VGA_BORDER_EN defined and an all-zero frame buffer, CONFIG_COLOURS=16'h1C00. Required:
   - row 0, row 479, column 0 and column 639 output 8'h1C;
   - interior pixels output 8'h00.
